// File: rtl/fwspi_memio_rdseq.sv
// Word-read sequencer for a memory-mapped SPI flash port.
// Turns 32-bit read requests into a byte stream for a serial transfer engine
// (command, address, optional dummy, four data bytes) and gathers the returned
// bytes into a little-endian word. Sequential reads of consecutive words keep
// chip select low and stream only the data bytes.
module fwspi_memio_rdseq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  input  logic        cfg_quad,
  input  logic [3:0]  cfg_dummy,
  output logic        xfer_resetn,
  output logic        din_valid,
  input  logic        din_ready,
  output logic [7:0]  din_data,
  output logic [3:0]  din_tag,
  output logic        din_cont,
  output logic        din_dspi,
  output logic        din_qspi,
  output logic        din_ddr,
  output logic        din_rd,
  input  logic        dout_valid,
  input  logic [7:0]  dout_data,
  input  logic [3:0]  dout_tag
);

  localparam logic [7:0] CMD_READ_SINGLE = 8'h03;
  localparam logic [7:0] CMD_READ_QUAD   = 8'h6B;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    WAIT,
    RESP
  } state_t;

  state_t      state, state_d;

  // Request context captured on accept
  logic [23:0] addr_q;
  logic        mode_q;
  logic [3:0]  dummy_q;

  // Shared byte index for ADDR (0..2) and DATA (0..3)
  logic [1:0]  cnt;

  // Tag-7 byte already collected for the current word
  logic        got_last;

  // Continuation tracking: chip select is still low and the flash is
  // positioned at next_addr in mode_q
  logic        cont_ok;
  logic [23:0] next_addr;

  logic [23:0] req_addr_al;
  logic        accept;
  logic        cont_hit;
  logic        din_hs;
  logic        last_now;
  logic        unused_addr_lsb;

  // Word addresses only; the two low address bits carry no meaning
  assign req_addr_al     = {req_addr[23:2], 2'b00};
  assign unused_addr_lsb = ^req_addr[1:0];

  assign accept   = (state == IDLE) && req_valid && !reset;
  assign cont_hit = cont_ok && (req_addr_al == next_addr) && (cfg_quad == mode_q);
  assign din_hs   = din_valid && din_ready;
  assign last_now = dout_valid && (dout_tag == 4'd7);

  // Fixed per-byte mode bits: always continue, never dual, never DDR
  assign din_cont = 1'b1;
  assign din_dspi = 1'b0;
  assign din_ddr  = 1'b0;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and byte-stream outputs; reset forces the idle-side values
  always_comb begin
    state_d     = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    xfer_resetn = 1'b1;
    din_valid   = 1'b0;
    din_data    = 8'h00;
    din_tag     = 4'h0;
    din_qspi    = 1'b0;
    din_rd      = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = cont_hit ? DATA : FLUSH;
        end
      end

      FLUSH: begin
        // One-cycle engine reset raises chip select and ends any open read
        xfer_resetn = 1'b0;
        state_d     = CMD;
      end

      CMD: begin
        din_valid = 1'b1;
        din_data  = mode_q ? CMD_READ_QUAD : CMD_READ_SINGLE;
        if (din_ready) begin
          state_d = ADDR;
        end
      end

      ADDR: begin
        din_valid = 1'b1;
        case (cnt)
          2'd0:    din_data = addr_q[23:16];
          2'd1:    din_data = addr_q[15:8];
          2'd2:    din_data = addr_q[7:0];
          default: din_data = 8'h00;
        endcase
        if (din_ready && (cnt == 2'd2)) begin
          state_d = (mode_q && (dummy_q != 4'd0)) ? DUMMY : DATA;
        end
      end

      DUMMY: begin
        // Engine interprets the low nibble as the number of dummy clocks
        din_valid = 1'b1;
        din_rd    = 1'b1;
        din_data  = {4'b0000, dummy_q};
        din_tag   = 4'd1;
        if (din_ready) begin
          state_d = DATA;
        end
      end

      DATA: begin
        din_valid = 1'b1;
        din_rd    = 1'b1;
        din_qspi  = mode_q;
        din_tag   = {2'b01, cnt};
        if (din_ready && (cnt == 2'd3)) begin
          state_d = (got_last || last_now) ? RESP : WAIT;
        end
      end

      WAIT: begin
        if (got_last || last_now) begin
          state_d = RESP;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      state_d     = IDLE;
      req_ready   = 1'b1;
      rsp_valid   = 1'b0;
      xfer_resetn = 1'b0;
      din_valid   = 1'b0;
      din_data    = 8'h00;
      din_tag     = 4'h0;
      din_qspi    = 1'b0;
      din_rd      = 1'b0;
    end
  end

  // Capture request address, mode and dummy count on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr_al;
      mode_q  <= cfg_quad;
      dummy_q <= cfg_dummy;
    end
  end

  // Byte index: ADDR wraps after its third byte, DATA wraps naturally 3->0
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      cnt <= 2'd0;
    end else if (din_hs && (state == ADDR)) begin
      cnt <= (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;
    end else if (din_hs && (state == DATA)) begin
      cnt <= cnt + 2'd1;
    end
  end

  // Remember that the final data byte came back, in case it beats the last accept
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      got_last <= 1'b0;
    end else if (last_now) begin
      got_last <= 1'b1;
    end
  end

  // Collect data-tagged bytes into their lanes; command/dummy returns are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data <= 32'h0;
    end else if (dout_valid && (dout_tag[3:2] == 2'b01)) begin
      rsp_data[{dout_tag[1:0], 3'b000} +: 8] <= dout_data;
    end
  end

  // Continuation bookkeeping; a wrap past the top of flash cannot continue
  always_ff @(posedge clk) begin
    if (reset) begin
      cont_ok   <= 1'b0;
      next_addr <= 24'h0;
    end else if (state == RESP) begin
      next_addr <= addr_q + 24'd4;
      cont_ok   <= (addr_q != 24'hFFFFFC);
    end
  end

endmodule

// File: tb/tb_fwspi_memio_rdseq.sv
// Directed testbench for fwspi_memio_rdseq with a one-cycle-latency engine model.
module tb_fwspi_memio_rdseq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = 24'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        cfg_quad = 1'b0;
  logic [3:0]  cfg_dummy = 4'h0;
  logic        xfer_resetn;
  logic        din_valid;
  logic        din_ready = 1'b1;
  logic [7:0]  din_data;
  logic [3:0]  din_tag;
  logic        din_cont, din_dspi, din_qspi, din_ddr, din_rd;
  logic        dout_valid = 1'b0;
  logic [7:0]  dout_data = 8'h0;
  logic [3:0]  dout_tag = 4'h0;

  fwspi_memio_rdseq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cfg_quad(cfg_quad), .cfg_dummy(cfg_dummy),
    .xfer_resetn(xfer_resetn),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_tag(din_tag),
    .din_cont(din_cont), .din_dspi(din_dspi), .din_qspi(din_qspi), .din_ddr(din_ddr), .din_rd(din_rd),
    .dout_valid(dout_valid), .dout_data(dout_data), .dout_tag(dout_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed traffic: {rd, qspi, tag[3:0], data[7:0]} per accepted byte
  logic [13:0] log_q[$];
  int          flush_cnt = 0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_last = 32'h0;
  int          cyc = 0;
  int          rsp_cyc = 0;
  int          last_dout_cyc = 0;

  logic        pend_v = 1'b0;
  logic [3:0]  pend_tag = 4'h0;
  logic [7:0]  ret [0:3];

  function automatic logic [13:0] mk(input logic rd, input logic q, input logic [3:0] tag,
                                     input logic [7:0] d);
    return {rd, q, tag, d};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor between active edges
  always @(negedge clk) begin
    pend_v = 1'b0;
    if (!reset) begin
      if (din_valid && din_ready) begin
        log_q.push_back({din_rd, din_qspi, din_tag, din_data});
        pend_v   = din_rd;
        pend_tag = din_tag;
      end
      if (!xfer_resetn) flush_cnt++;
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_last = rsp_data;
        rsp_cyc  = cyc;
      end
      if (dout_valid && dout_tag == 4'd7) last_dout_cyc = cyc;
    end
  end

  // Engine: returns one byte per read-flagged accept, one cycle later
  always @(posedge clk) begin
    #1;
    dout_valid = pend_v;
    dout_tag   = pend_tag;
    dout_data  = pend_tag[2] ? ret[pend_tag[1:0]] : 8'hEE;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [23:0] a, input logic q, input logic [3:0] d);
    for (int i = 0; i < 50; i++) begin
      if (req_ready) break;
      tick();
    end
    req_addr  = a;
    cfg_quad  = q;
    cfg_dummy = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int r0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_cnt > r0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick(); tick(); tick();
  endtask

  task automatic set_ret(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3);
    ret[0] = b0; ret[1] = b1; ret[2] = b2; ret[3] = b3;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || din_valid !== 1'b0 ||
        din_tag !== 4'h0 || xfer_resetn !== 1'b0) begin
      errors++;
      $display("FAIL reset_during: rdy=%b rsp=%b dv=%b tag=%h xrn=%b required 1 0 0 0 0",
               req_ready, rsp_valid, din_valid, din_tag, xfer_resetn);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 ||
        din_valid !== 1'b0 || xfer_resetn !== 1'b1) begin
      errors++;
      $display("FAIL reset_after: rdy=%b rsp=%b data=%h dv=%b xrn=%b required 1 0 0 0 1",
               req_ready, rsp_valid, rsp_data, din_valid, xfer_resetn);
    end
    checks++;
    if (din_cont !== 1'b1 || din_dspi !== 1'b0 || din_ddr !== 1'b0) begin
      errors++;
      $display("FAIL fixed_mode: cont=%b dspi=%b ddr=%b required 1 0 0", din_cont, din_dspi, din_ddr);
    end
  endtask

  task automatic test_single();
    int s, f0, r0;
    bit ok;
    logic [13:0] exp [0:7];
    exp = '{mk(0,0,0,8'h03), mk(0,0,0,8'h00), mk(0,0,0,8'h01), mk(0,0,0,8'h00),
            mk(1,0,4,8'h00), mk(1,0,5,8'h00), mk(1,0,6,8'h00), mk(1,0,7,8'h00)};
    set_ret(8'h11, 8'h22, 8'h33, 8'h44);
    s = log_q.size(); f0 = flush_cnt; r0 = rsp_cnt;
    start_req(24'h000102, 1'b0, 4'h0);
    wait_rsp(r0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: no rsp_valid within bound"); end
    checks++;
    if (log_q.size() - s !== 8) begin
      errors++; $display("FAIL single_count: got %0d bytes required 8", log_q.size() - s);
    end
    for (int i = 0; i < 8 && s + i < log_q.size(); i++) begin
      checks++;
      if (log_q[s+i] !== exp[i]) begin
        errors++; $display("FAIL single_byte%0d: got %h required %h", i, log_q[s+i], exp[i]);
      end
    end
    checks++;
    if (rsp_last !== 32'h44332211) begin
      errors++; $display("FAIL single_data: got %h required 44332211", rsp_last);
    end
    checks++;
    if (rsp_cnt - r0 !== 1 || flush_cnt - f0 !== 1) begin
      errors++; $display("FAIL single_pulses: rsp %0d flush %0d required 1 1", rsp_cnt - r0, flush_cnt - f0);
    end
    checks++;
    if (rsp_cyc < last_dout_cyc + 1) begin
      errors++; $display("FAIL single_latency: rsp cycle %0d last byte cycle %0d required gap >= 1",
                         rsp_cyc, last_dout_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int s, f0, r0;
    bit ok;
    logic [13:0] exp [0:3];
    exp = '{mk(1,0,4,8'h00), mk(1,0,5,8'h00), mk(1,0,6,8'h00), mk(1,0,7,8'h00)};
    set_ret(8'h55, 8'h66, 8'h77, 8'h88);
    s = log_q.size(); f0 = flush_cnt; r0 = rsp_cnt;
    start_req(24'h000104, 1'b0, 4'h0);
    wait_rsp(r0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: no rsp_valid within bound"); end
    checks++;
    if (log_q.size() - s !== 4 || flush_cnt - f0 !== 0) begin
      errors++; $display("FAIL b2b_count: got %0d bytes %0d flushes required 4 0",
                         log_q.size() - s, flush_cnt - f0);
    end
    for (int i = 0; i < 4 && s + i < log_q.size(); i++) begin
      checks++;
      if (log_q[s+i] !== exp[i]) begin
        errors++; $display("FAIL b2b_byte%0d: got %h required %h", i, log_q[s+i], exp[i]);
      end
    end
    checks++;
    if (rsp_last !== 32'h88776655) begin
      errors++; $display("FAIL b2b_data: got %h required 88776655", rsp_last);
    end
  endtask

  task automatic test_new_addr();
    int s, f0, r0;
    bit ok;
    logic [13:0] exp [0:3];
    exp = '{mk(0,0,0,8'h03), mk(0,0,0,8'h00), mk(0,0,0,8'h02), mk(0,0,0,8'h00)};
    set_ret(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    s = log_q.size(); f0 = flush_cnt; r0 = rsp_cnt;
    start_req(24'h000200, 1'b0, 4'h0);
    wait_rsp(r0, ok);
    checks++;
    if (!ok || log_q.size() - s !== 8 || flush_cnt - f0 !== 1) begin
      errors++; $display("FAIL newaddr_shape: ok=%b bytes %0d flushes %0d required 1 8 1",
                         ok, log_q.size() - s, flush_cnt - f0);
    end
    for (int i = 0; i < 4 && s + i < log_q.size(); i++) begin
      checks++;
      if (log_q[s+i] !== exp[i]) begin
        errors++; $display("FAIL newaddr_byte%0d: got %h required %h", i, log_q[s+i], exp[i]);
      end
    end
    checks++;
    if (rsp_last !== 32'hEFBEADDE) begin
      errors++; $display("FAIL newaddr_data: got %h required efbeadde", rsp_last);
    end
  endtask

  task automatic test_quad();
    int s, f0, r0;
    bit ok;
    logic [13:0] exp [0:8];
    logic [13:0] exp0 [0:7];
    exp = '{mk(0,0,0,8'h6B), mk(0,0,0,8'h00), mk(0,0,0,8'h03), mk(0,0,0,8'h00),
            mk(1,0,1,8'h08), mk(1,1,4,8'h00), mk(1,1,5,8'h00), mk(1,1,6,8'h00),
            mk(1,1,7,8'h00)};
    set_ret(8'hA0, 8'hB1, 8'hC2, 8'hD3);
    s = log_q.size(); f0 = flush_cnt; r0 = rsp_cnt;
    start_req(24'h000300, 1'b1, 4'd8);
    wait_rsp(r0, ok);
    checks++;
    if (!ok || log_q.size() - s !== 9 || flush_cnt - f0 !== 1) begin
      errors++; $display("FAIL quad_shape: ok=%b bytes %0d flushes %0d required 1 9 1",
                         ok, log_q.size() - s, flush_cnt - f0);
    end
    for (int i = 0; i < 9 && s + i < log_q.size(); i++) begin
      checks++;
      if (log_q[s+i] !== exp[i]) begin
        errors++; $display("FAIL quad_byte%0d: got %h required %h", i, log_q[s+i], exp[i]);
      end
    end
    checks++;
    if (rsp_last !== 32'hD3C2B1A0) begin
      errors++; $display("FAIL quad_data: got %h required d3c2b1a0", rsp_last);
    end

    // Zero dummy clocks: the dummy byte disappears from the stream
    exp0 = '{mk(0,0,0,8'h6B), mk(0,0,0,8'h00), mk(0,0,0,8'h05), mk(0,0,0,8'h00),
             mk(1,1,4,8'h00), mk(1,1,5,8'h00), mk(1,1,6,8'h00), mk(1,1,7,8'h00)};
    set_ret(8'h01, 8'h02, 8'h03, 8'h04);
    s = log_q.size(); r0 = rsp_cnt;
    start_req(24'h000500, 1'b1, 4'd0);
    wait_rsp(r0, ok);
    checks++;
    if (!ok || log_q.size() - s !== 8) begin
      errors++; $display("FAIL quad0_count: ok=%b bytes %0d required 1 8", ok, log_q.size() - s);
    end
    for (int i = 0; i < 8 && s + i < log_q.size(); i++) begin
      checks++;
      if (log_q[s+i] !== exp0[i]) begin
        errors++; $display("FAIL quad0_byte%0d: got %h required %h", i, log_q[s+i], exp0[i]);
      end
    end
    checks++;
    if (rsp_last !== 32'h04030201) begin
      errors++; $display("FAIL quad0_data: got %h required 04030201", rsp_last);
    end
  endtask

  task automatic test_stall();
    int s, r0;
    bit ok, reached;
    logic [13:0] exp [0:3];
    exp = '{mk(0,0,0,8'h03), mk(0,0,0,8'h12), mk(0,0,0,8'h34), mk(0,0,0,8'h54)};
    set_ret(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    s = log_q.size(); r0 = rsp_cnt;
    start_req(24'h123456, 1'b0, 4'h0);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (log_q.size() - s == 2) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL stall_reach: second address byte never presented"); end
    din_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (din_valid !== 1'b1 || din_data !== 8'h34 || din_tag !== 4'h0) begin
        errors++; $display("FAIL stall_hold%0d: valid=%b data=%h tag=%h required 1 34 0",
                           i, din_valid, din_data, din_tag);
      end
      tick();
    end
    din_ready = 1'b1;
    wait_rsp(r0, ok);
    checks++;
    if (!ok || log_q.size() - s !== 8) begin
      errors++; $display("FAIL stall_count: ok=%b bytes %0d required 1 8", ok, log_q.size() - s);
    end
    for (int i = 0; i < 4 && s + i < log_q.size(); i++) begin
      checks++;
      if (log_q[s+i] !== exp[i]) begin
        errors++; $display("FAIL stall_byte%0d: got %h required %h", i, log_q[s+i], exp[i]);
      end
    end
    checks++;
    if (rsp_last !== 32'hD4C3B2A1) begin
      errors++; $display("FAIL stall_data: got %h required d4c3b2a1", rsp_last);
    end
  endtask

  task automatic test_reset_mid();
    int s, f0, r0;
    bit ok, reached;
    set_ret(8'h99, 8'h98, 8'h97, 8'h96);
    s = log_q.size(); r0 = rsp_cnt;
    start_req(24'h000600, 1'b0, 4'h0);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (log_q.size() - s >= 5) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL midreset_reach: DATA never started"); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (rsp_cnt !== r0) begin
      errors++; $display("FAIL midreset_rsp: got %0d responses required 0", rsp_cnt - r0);
    end
    // next_addr is 0 after reset, but continuation must not be taken
    set_ret(8'h10, 8'h20, 8'h30, 8'h40);
    s = log_q.size(); f0 = flush_cnt; r0 = rsp_cnt;
    start_req(24'h000000, 1'b0, 4'h0);
    wait_rsp(r0, ok);
    checks++;
    if (!ok || log_q.size() - s !== 8 || flush_cnt - f0 !== 1) begin
      errors++; $display("FAIL midreset_next: ok=%b bytes %0d flushes %0d required 1 8 1",
                         ok, log_q.size() - s, flush_cnt - f0);
    end
    checks++;
    if (log_q.size() > s && log_q[s] !== mk(0,0,0,8'h03)) begin
      errors++; $display("FAIL midreset_cmd: got %h required %h", log_q[s], mk(0,0,0,8'h03));
    end
    checks++;
    if (rsp_last !== 32'h40302010) begin
      errors++; $display("FAIL midreset_data: got %h required 40302010", rsp_last);
    end
  endtask

  task automatic test_wrap();
    int s, f0, r0;
    bit ok;
    set_ret(8'hF0, 8'hF1, 8'hF2, 8'hF3);
    r0 = rsp_cnt;
    start_req(24'hFFFFFC, 1'b0, 4'h0);
    wait_rsp(r0, ok);
    checks++;
    if (!ok || rsp_last !== 32'hF3F2F1F0) begin
      errors++; $display("FAIL wrap_top: ok=%b data %h required 1 f3f2f1f0", ok, rsp_last);
    end
    s = log_q.size(); f0 = flush_cnt; r0 = rsp_cnt;
    start_req(24'h000000, 1'b0, 4'h0);
    wait_rsp(r0, ok);
    checks++;
    if (!ok || log_q.size() - s !== 8 || flush_cnt - f0 !== 1) begin
      errors++; $display("FAIL wrap_restart: ok=%b bytes %0d flushes %0d required 1 8 1",
                         ok, log_q.size() - s, flush_cnt - f0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_new_addr();
    test_quad();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
